// File: rtl/dram_frame_writer.sv
// rtl/dram_frame_writer.sv - AXI3 write master draining a 64-bit stream into a circular DRAM frame buffer
// Optional sticky write-response error flag: FRAMEWRITER_BRESP_ERR_EN
module dram_frame_writer (
    input  logic        ACLK,
    input  logic        rst_n,
    output logic [31:0] M_AXI_AWADDR,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [3:0]  M_AXI_AWLEN,
    output logic [1:0]  M_AXI_AWSIZE,
    output logic [1:0]  M_AXI_AWBURST,
    output logic [63:0] M_AXI_WDATA,
    output logic [7:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    output logic        M_AXI_WLAST,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        start,
    input  logic        stop,
    input  logic        burst_ready,
    input  logic [31:0] FRAMEBUF_ADDR,
    input  logic [31:0] FRAMEBUF_NBYTES,
    output logic [31:0] FRAMEBUF_CURADDR,
    output logic [31:0] frames_written,
`ifdef FRAMEWRITER_BRESP_ERR_EN
    output logic        wr_error,
`endif
    input  logic        din_valid,
    output logic        din_ready,
    input  logic [63:0] din
);

    localparam logic [2:0] S_INIT = 3'd0;
    localparam logic [2:0] S_IDLE = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_DATA = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    logic [2:0]  r_state;
    logic [31:0] r_awaddr;
    logic [3:0]  r_beat;
    logic        r_stopping;
    logic [31:0] r_frames;

    logic [31:0] w_next_addr;
    logic [31:0] w_buf_end;
    logic        w_wrap;
    logic        w_beat_fire;
    logic        w_resp_fire;

    assign w_next_addr = r_awaddr + 32'd128;
    assign w_buf_end   = FRAMEBUF_ADDR + FRAMEBUF_NBYTES;
    assign w_wrap      = (w_next_addr == w_buf_end);
    assign w_beat_fire = (r_state == S_DATA) && din_valid && M_AXI_WREADY;
    assign w_resp_fire = (r_state == S_RESP) && M_AXI_BVALID;

    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_INIT;
            r_awaddr   <= 32'd0;
            r_beat     <= 4'd0;
            r_stopping <= 1'b0;
            r_frames   <= 32'd0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (start) begin
                        r_awaddr <= FRAMEBUF_ADDR;
                        r_state  <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (burst_ready)
                        r_state <= S_ADDR;
                end
                S_ADDR: begin
                    if (M_AXI_AWREADY) begin
                        r_beat  <= 4'd15;
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_beat_fire) begin
                        r_beat <= r_beat - 4'd1;
                        if (r_beat == 4'd0)
                            r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    // Error responses still advance: the frame is never retried.
                    if (M_AXI_BVALID) begin
                        r_awaddr <= w_wrap ? FRAMEBUF_ADDR : w_next_addr;
                        if (w_wrap)
                            r_frames <= r_frames + 32'd1;
                        r_state <= (r_stopping && w_wrap) ? S_INIT : S_IDLE;
                    end
                end
                default: r_state <= S_INIT;
            endcase

            if (stop)
                r_stopping <= 1'b1;
            else if (r_state == S_INIT)
                r_stopping <= 1'b0;
        end
    end

`ifdef FRAMEWRITER_BRESP_ERR_EN
    logic r_wr_error;

    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n)
            r_wr_error <= 1'b0;
        else if ((r_state == S_INIT) && start)
            r_wr_error <= 1'b0;
        else if (w_resp_fire && (M_AXI_BRESP != 2'b00))
            r_wr_error <= 1'b1;
    end

    assign wr_error = r_wr_error;
`else
    logic w_unused_bresp;
    assign w_unused_bresp = ^{M_AXI_BRESP, w_resp_fire};
`endif

    assign M_AXI_AWADDR     = r_awaddr;
    assign M_AXI_AWVALID    = (r_state == S_ADDR);
    assign M_AXI_AWLEN      = 4'b1111;
    assign M_AXI_AWSIZE     = 2'b11;
    assign M_AXI_AWBURST    = 2'b01;
    assign M_AXI_WDATA      = din;
    assign M_AXI_WSTRB      = 8'hFF;
    assign M_AXI_WVALID     = (r_state == S_DATA) && din_valid;
    assign M_AXI_WLAST      = (r_state == S_DATA) && (r_beat == 4'd0);
    assign M_AXI_BREADY     = (r_state == S_RESP);
    assign din_ready        = (r_state == S_DATA) && M_AXI_WREADY;
    assign FRAMEBUF_CURADDR = r_awaddr;
    assign frames_written   = r_frames;

endmodule

// File: doc/dram_frame_writer.md
# dram_frame_writer

AXI3 write master that drains a 64-bit pixel stream into a circular DRAM frame buffer as fixed 128-byte bursts (16 beats × 8 bytes, INCR). It is the write-side counterpart of the display reader and sits between the camera-side stream FIFO and the Zynq HP port. It is started and stopped from the control registers, and it stops only on a frame boundary.

## Interface
Parameters: none. Burst geometry is fixed.

Ports (clock and reset first):
- ACLK  in  1  sole clock.
- rst_n  in  1  reset: asynchronous assert, active-low.
- M_AXI_AWADDR  out  32  burst start address; also exported as FRAMEBUF_CURADDR.
- M_AXI_AWVALID  out  1  write address valid.
- M_AXI_AWREADY  in  1  write address ready.
- M_AXI_AWLEN  out  4  constant 4'b1111 (16 beats).
- M_AXI_AWSIZE  out  2  constant 2'b11 (8 bytes per beat).
- M_AXI_AWBURST  out  2  constant 2'b01 (INCR).
- M_AXI_WDATA  out  64  equals din.
- M_AXI_WSTRB  out  8  constant 8'hFF.
- M_AXI_WVALID  out  1  write data valid.
- M_AXI_WREADY  in  1  write data ready.
- M_AXI_WLAST  out  1  high on beat 16 of a burst.
- M_AXI_BVALID  in  1  write response valid.
- M_AXI_BREADY  out  1  write response ready.
- M_AXI_BRESP  in  2  write response code.
- start  in  1  arm the writer from INIT.
- stop  in  1  request a stop at the next frame end.
- burst_ready  in  1  upstream FIFO holds at least 16 words.
- FRAMEBUF_ADDR  in  32  buffer base; must be 128-byte aligned.
- FRAMEBUF_NBYTES  in  32  buffer size; must be a nonzero multiple of 128.
- FRAMEBUF_CURADDR  out  32  equals M_AXI_AWADDR.
- frames_written  out  32  count of completed frames.
- din_valid  in  1  stream word valid.
- din_ready  out  1  stream word accepted.
- din  in  64  stream word.
- wr_error  out  1  sticky error flag; present only with the macro described under Configuration.

## Operation
- States: INIT, IDLE, ADDR, DATA, RESP.
- INIT: all AXI valids are low. When `start` is seen, load AWADDR ← FRAMEBUF_ADDR and go to IDLE.
- IDLE: when `burst_ready` is seen, go to ADDR.
- ADDR: AWVALID=1, held until the AWREADY handshake. On the handshake, set beat counter ← 15 and go to DATA. AWADDR must be stable while AWVALID is high.
- DATA: WVALID=din_valid, din_ready=M_AXI_WREADY, WLAST=(beat counter==0).
  - A beat is transferred when din_valid && M_AXI_WREADY.
  - Each beat decrements the counter.
  - A beat taken while the counter is 0 moves the state to RESP.
- RESP: BREADY=1. When BVALID is seen:
  - AWADDR ← wrap ? FRAMEBUF_ADDR : AWADDR+128.
  - On wrap, frames_written increments (modulo 2^32).
  - Next state is INIT if (stopping && wrap), otherwise IDLE.
- wrap = (AWADDR+128 == FRAMEBUF_ADDR+FRAMEBUF_NBYTES), using 32-bit arithmetic.
- stopping:
  - Set by `stop`; `stop` has priority over the clear.
  - Cleared while the state is INIT.
  - A stop request during a burst completes the current frame.
- din_ready and WVALID are 0 outside DATA, so no words are consumed outside a burst.
- BRESP is ignored for flow control; an error response still advances the address.
- FRAMEBUF_ADDR and FRAMEBUF_NBYTES are sampled live. Software changes them only while the writer is in INIT.

## Timing
- Reset values:
  - state=INIT, AWADDR=0, beat counter=0, stopping=0, frames_written=0, wr_error=0.
  - All valid and ready outputs are 0; WLAST=0.
- Address phase: AWVALID rises in the cycle after `burst_ready` is sampled in IDLE.
- Data phase: DATA begins in the cycle after the AW handshake. The minimum burst is 16 cycles with zero stalls.
- Response phase: RESP lasts at least 1 cycle.
- Minimum total: 1 (IDLE) + 1 (ADDR) + 16 (DATA) + 1 (RESP) = 19 cycles per burst.
- Address and data phases never overlap, and at most one transaction is outstanding.
- AWADDR and frames_written update on the clock edge where BVALID is sampled in RESP.
- Reset asserted mid-burst: return to INIT immediately, with no WLAST and no BREADY. The interconnect is reset together with this block.
- `start` outside INIT is ignored. `start` and `stop` in the same cycle in INIT: the writer arms, and stopping=1. It then stops after one frame.

## Configuration
- FRAMEWRITER_BRESP_ERR_EN defined:
  - wr_error is a port.
  - It is set in the cycle after BVALID is sampled in RESP with BRESP≠2'b00.
  - It stays set until rst_n or `start` is seen in INIT.
- FRAMEWRITER_BRESP_ERR_EN not defined:
  - The wr_error port is absent.
  - BRESP is unused.

## Test plan
1. Single burst: NBYTES=128, ADDR=0x1000_0000, AWREADY, WREADY and BVALID always high, 16 words 0..15 → one AW at 0x1000_0000 with LEN=15; WDATA 0..15; WLAST on beat 16; AWADDR returns to 0x1000_0000; frames_written=1.
2. Wrap: NBYTES=384, continuous data → AW addresses base, base+0x80, base+0x100, base, …; frames_written increments on every third response.
3. Backpressure: WREADY low on beats 3–7 and din_valid low on beat 10 → exactly 16 beats transferred with no duplicated or dropped word; WLAST only on the last beat; din_ready mirrors WREADY.
4. Stop: `stop` pulsed mid-burst 2 of 3 → burst 3 completes, wrap occurs, the writer enters INIT, and no further AWVALID appears until `start`.
5. Async reset asserted during DATA beat 8 → all outputs go to reset values in the same cycle; after release, no AWVALID until `start`.
6. With FRAMEWRITER_BRESP_ERR_EN: BRESP=2'b10 on burst 2 → wr_error=1 from the next cycle; it is held through later OKAY responses and cleared by `start` in INIT.
